// File: rtl/aes_key_expand_seq.sv
// aes_key_expand_seq: iterative AES-128 key schedule, one round key per clock.
// Slot 0 is loaded with the cipher key on an accepted start; slots 1..10 follow
// on the next ten edges. The round-key stream outputs (rk_valid/rk_index/rk_data)
// exist only when AES_KEYEXP_STREAM_EN is defined.

// Forward AES S-box, pure table lookup.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] y
);
    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign y = SBOX[a];
endmodule

module aes_key_expand_seq #(
    parameter int NR = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [127:0]              key,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      key_valid,
    output logic [128*(NR+1)-1:0]     expanded_key
`ifdef AES_KEYEXP_STREAM_EN
    ,
    output logic                      rk_valid,
    output logic [3:0]                rk_index,
    output logic [127:0]              rk_data
`endif
);
    localparam int EKW = 128 * (NR + 1);
    localparam logic [3:0] LAST = 4'(NR);

    typedef enum logic {IDLE, EXPAND} state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [7:0]      rcon_q, rcon_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            kv_q, kv_d;
    logic [EKW-1:0]  ek_q, ek_d;
`ifdef AES_KEYEXP_STREAM_EN
    logic            rkv_q, rkv_d;
    logic [3:0]      rki_q, rki_d;
    logic [127:0]    rkd_q, rkd_d;
`endif

    logic [127:0]    prev_rk;
    logic [127:0]    new_rk;
    logic [3:0][7:0] rot_w;
    logic [3:0][7:0] sub_w;
    logic [31:0]     g_w;
    logic [7:0]      rcon_next;

    // Select round key r-1 (r = cnt_q) as the source for the next round key.
    always_comb begin
        prev_rk = '0;
        for (int i = 0; i < NR; i++) begin
            if (cnt_q == 4'(i + 1)) prev_rk = ek_q[128*i +: 128];
        end
    end

    // RotWord on w3: byte 0 moves to byte 3.
    assign rot_w = {prev_rk[103:96], prev_rk[127:104]};

    genvar b;
    generate
        for (b = 0; b < 4; b++) begin : g_sbox
            aes_sbox u_sbox (.a(rot_w[b]), .y(sub_w[b]));
        end
    endgenerate

    assign g_w       = sub_w ^ {24'h0, rcon_q};
    assign rcon_next = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

    // Chained word XORs producing round key r.
    always_comb begin
        new_rk[31:0]   = prev_rk[31:0]   ^ g_w;
        new_rk[63:32]  = prev_rk[63:32]  ^ new_rk[31:0];
        new_rk[95:64]  = prev_rk[95:64]  ^ new_rk[63:32];
        new_rk[127:96] = prev_rk[127:96] ^ new_rk[95:64];
    end

    // Next-state logic: accept in IDLE, fill one slot per cycle in EXPAND.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rcon_d  = rcon_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        kv_d    = kv_q;
        ek_d    = ek_q;
`ifdef AES_KEYEXP_STREAM_EN
        rkv_d   = 1'b0;
        rki_d   = rki_q;
        rkd_d   = rkd_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    ek_d[127:0] = key;
                    kv_d        = 1'b0;
                    cnt_d       = 4'd1;
                    rcon_d      = 8'h01;
                    busy_d      = 1'b1;
                    state_d     = EXPAND;
`ifdef AES_KEYEXP_STREAM_EN
                    rkv_d       = 1'b1;
                    rki_d       = 4'd0;
                    rkd_d       = key;
`endif
                end
            end
            EXPAND: begin
                for (int i = 1; i <= NR; i++) begin
                    if (cnt_q == 4'(i)) ek_d[128*i +: 128] = new_rk;
                end
                cnt_d  = cnt_q + 4'd1;
                rcon_d = rcon_next;
`ifdef AES_KEYEXP_STREAM_EN
                rkv_d  = 1'b1;
                rki_d  = cnt_q;
                rkd_d  = new_rk;
`endif
                if (cnt_q == LAST) begin
                    busy_d  = 1'b0;
                    kv_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; async active-low reset discards any partial schedule.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rcon_q  <= 8'h01;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            kv_q    <= 1'b0;
            ek_q    <= '0;
`ifdef AES_KEYEXP_STREAM_EN
            rkv_q   <= 1'b0;
            rki_q   <= 4'd0;
            rkd_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rcon_q  <= rcon_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            kv_q    <= kv_d;
            ek_q    <= ek_d;
`ifdef AES_KEYEXP_STREAM_EN
            rkv_q   <= rkv_d;
            rki_q   <= rki_d;
            rkd_q   <= rkd_d;
`endif
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign key_valid    = kv_q;
    assign expanded_key = ek_q;
`ifdef AES_KEYEXP_STREAM_EN
    assign rk_valid     = rkv_q;
    assign rk_index     = rki_q;
    assign rk_data      = rkd_q;
`endif
endmodule

// File: doc/aes_key_expand_seq.md
# aes_key_expand_seq

Sequential AES-128 key-expansion unit that sits directly upstream of `AES_top`. It accepts a 128-bit cipher key and generates the eleven round keys iteratively, one per clock. It drives the 1408-bit `expanded_key` bus consumed by the encrypt/decrypt datapath and raises a valid flag once all round keys are stable.

## Interface
- `NR`, 10, number of rounds; fixed at 10 for AES-128; other values unsupported.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous reset, active-low; one clock; reset is asynchronous and active-low.
- `key`  in  128  cipher key, byte 0 in `key[7:0]` (LSB-first byte order, same as `AES_top`); sampled only on an accepted `start`.
- `start`  in  1  request expansion; accepted only when `busy`=0.
- `busy`  out  1  high while round keys 1..10 are being generated.
- `done`  out  1  one-cycle pulse on completion.
- `key_valid`  out  1  level; high while `expanded_key` holds a complete schedule for the last accepted key.
- `expanded_key`  out  1408  round key i at `[128*i+127 : 128*i]`, i = 0..10.

## Operation
- States: IDLE, EXPAND. Reset → IDLE.
- IDLE, `start`=1: latch `key` into slot 0, clear `key_valid`, round counter ← 1, rcon ← 8'h01, go to EXPAND, `busy` ← 1.
- IDLE, `start`=0: hold all outputs.
- EXPAND: each cycle compute round key r from round key r−1 into slot r; counter +1; rcon ← xtime(rcon) (shift left, XOR 8'h1B on carry out of bit 7).
- Word layout: w0 = `rk[31:0]` … w3 = `rk[127:96]`, byte order LSB-first within each word.
- g(w3) = SubWord(RotWord(w3)) XOR {rcon in byte 0}; RotWord moves byte 0 to byte 3.
- new w0 = w0 ^ g; w1 = w1 ^ new w0; w2 = w2 ^ new w1; w3 = w3 ^ new w2.
- Four combinational S-box instances (FIPS-197 forward table), one per byte of w3.
- On writing slot 10: `busy` ← 0, `key_valid` ← 1, `done` ← 1 for one cycle, return to IDLE.
- `start` while `busy`=1: ignored, no effect on the running expansion.
- During EXPAND, slots not yet rewritten keep their previous contents; consumers must qualify with `key_valid`.

## Timing
- Reset values: `busy`=0, `done`=0, `key_valid`=0, `expanded_key`=0, counter=0, rcon=8'h01.
- `start` accepted at edge E0: slot 0 valid after E0; slot r written at edge E0+r; `key_valid`/`done` high after E0+10.
- Total latency: 11 edges from acceptance to `key_valid`; back-to-back `start` held high restarts at the edge following completion, so throughput is one schedule per 11 cycles.
- `start` and completion in the same cycle: completion takes effect; `start` is not accepted because `busy`=1 at that edge.
- Reset asserted mid-expansion: immediate return to reset values; the partial schedule is discarded.
- Rcon sequence across rounds 1..10: 01,02,04,08,10,20,40,80,1B,36.

## Configuration
- `AES_KEYEXP_STREAM_EN` defined: adds outputs `rk_valid` (1), `rk_index` (4), `rk_data` (128). These carry each round key, including slot 0, in the cycle after it is written, for pipelined round consumers. `rk_valid` is high for exactly 11 consecutive cycles per expansion. All three reset to 0.
- Undefined: these ports are absent and behaviour is otherwise identical.

## Test plan
- FIPS-197 key 128'h3C4FCF098815F7ABA6D2AE2816157E2B, pulse `start` → after 11 edges `key_valid`=1 and `done` pulses once. Slot 1 = 128'h05766C2A3939A323B12C548817FEFAA0; slot 10 = 128'hA60C63B6C80C3FE18925EEC9A8F914D0.
- Key 128'h100F0E0D0C0B0A090807060504030201 → slot 0 equals `key`, and all slots match a software model. `AES_top` then encrypts 128'h54494D47206E616C6F4E20726F6E6F43, and the decrypted output equals the plaintext.
- `start` re-pulsed at cycles 3 and 7 of an expansion → ignored; the result is identical to the first scenario and `done` pulses exactly once.
- `rst` driven low at cycle 5 of an expansion → `busy`, `key_valid` and `done` go to 0 immediately and `expanded_key`=0. A fresh `start` after release completes correctly.
- `start` held high continuously with the key changed after the first `done` → the second expansion begins on the edge after the first completes, `key_valid` drops for 10 cycles, and the final schedule matches the new key.
- With `AES_KEYEXP_STREAM_EN`: `rk_index` steps 0..10 on consecutive cycles, and `rk_data` equals the matching `expanded_key` slot at each step.
